// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) ALU.
//   - default field degree, reduction polynomial and square-count width
//   - operation encodings (OP_MULT, OP_SQR, OP_ADD, OP_RSVD)
//   - control FSM state encoding
package gf2m_pkg;

  // x^163 + x^7 + x^6 + x^3 + 1, leading term implicit.
  localparam int unsigned  GF2M_M    = 163;
  localparam logic [162:0] GF2M_POLY = 163'hC9;
  localparam int unsigned  GF2M_K_W  = 8;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_SQR  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFin  = 2'b10
  } state_e;

endpackage

// File: rtl/gf2m_square.sv
// Combinational squarer in GF(2^M), polynomial basis.
//   a_i  : operand, bit i = coefficient of x^i
//   sq_o : a_i^2 reduced modulo x^M + POLY
module gf2m_square
  import gf2m_pkg::*;
#(
  parameter int unsigned    M    = GF2M_M,
  parameter logic [M-1:0]   POLY = GF2M_POLY
) (
  input  logic [M-1:0] a_i,
  output logic [M-1:0] sq_o
);

  logic [2*M-2:0] t;

  always_comb begin
    // Squaring is carry-free: coefficient i moves to position 2i.
    t = '0;
    for (int i = 0; i < int'(M); i++) begin
      t[2*i] = a_i[i];
    end
    // Fold high terms down from the top; x^M == POLY.
    for (int i = 2 * int'(M) - 2; i >= int'(M); i--) begin
      if (t[i]) begin
        t[i]          = 1'b0;
        t[i-M +: M]   = t[i-M +: M] ^ POLY;
      end
    end
    sq_o = t[M-1:0];
  end

endmodule

// File: rtl/gf2m_alu.sv
// Multi-cycle GF(2^M) ALU: bit-serial multiply, repeated squaring and add.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   start_i  : request pulse, sampled only when idle
//   op_i     : 00 MULT, 01 SQR, 10 ADD, 11 reserved (err)
//   k_i      : number of squarings for SQR (0 treated as 1)
//   a_i, b_i : field operands
//   c_o      : registered result, held until the next completion
//   busy_o   : operation in progress
//   done_o   : one-cycle pulse when c_o updates
//   err_o    : asserted with done_o for the reserved op
// Build option: GF2M_SQR_CHAIN_EN enables k-fold squaring; without it SQR
// always performs a single squaring and k_i is ignored.
module gf2m_alu
  import gf2m_pkg::*;
#(
  parameter int unsigned  M    = GF2M_M,
  parameter logic [M-1:0] POLY = GF2M_POLY,
  parameter int unsigned  K_W  = GF2M_K_W
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [1:0]     op_i,
  input  logic [K_W-1:0] k_i,
  input  logic [M-1:0]   a_i,
  input  logic [M-1:0]   b_i,
  output logic [M-1:0]   c_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);

  // Counter must hold both M (multiply) and the largest k.
  localparam int unsigned CntW = ($clog2(M + 1) > K_W) ? $clog2(M + 1) : K_W;

  state_e          state_q, state_d;
  logic [M-1:0]    a_q, a_d;
  logic [M-1:0]    b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [M-1:0]    z_q, z_d;
  logic [M-1:0]    c_q, c_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [CntW-1:0] cnt_load;
  logic [M-1:0]    z_xtime;
  logic [M-1:0]    mul_step;
  logic [M-1:0]    sq_out;

  gf2m_square #(
    .M    (M),
    .POLY (POLY)
  ) u_square (
    .a_i  (z_q),
    .sq_o (sq_out)
  );

  // Z*x mod POLY, then accumulate A when the current multiplier bit is set.
  // b_q is shifted left each step so its MSB walks from B[M-1] to B[0].
  assign z_xtime  = {z_q[M-2:0], 1'b0} ^ (z_q[M-1] ? POLY : '0);
  assign mul_step = z_xtime ^ (b_q[M-1] ? a_q : '0);

`ifndef GF2M_SQR_CHAIN_EN
  logic unused_k;
  assign unused_k = ^k_i;
`endif

  always_comb begin
    cnt_load = CntW'(1);
    case (op_i)
      OP_MULT: cnt_load = CntW'(M);
`ifdef GF2M_SQR_CHAIN_EN
      OP_SQR:  cnt_load = (k_i == '0) ? CntW'(1) : CntW'(k_i);
`else
      OP_SQR:  cnt_load = CntW'(1);
`endif
      default: cnt_load = CntW'(1);
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (cnt_q == CntW'(1)) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_o = (state_q == StRun) || (state_q == StFin);
  end

  // Datapath next-state.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    cnt_d  = cnt_q;
    z_d    = z_q;
    c_d    = c_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a_d   = a_i;
          b_d   = b_i;
          op_d  = op_i;
          cnt_d = cnt_load;
          z_d   = (op_i == OP_SQR) ? a_i : '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        case (op_q)
          OP_MULT: begin
            z_d = mul_step;
            b_d = b_q << 1;
          end
          OP_SQR:  z_d = sq_out;
          OP_ADD:  z_d = a_q ^ b_q;
          default: z_d = '0;
        endcase
      end
      StFin: begin
        c_d    = z_q;
        done_d = 1'b1;
        err_d  = (op_q == OP_RSVD);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_MULT;
      cnt_q  <= '0;
      z_q    <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
      c_q    <= c_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign c_o    = c_q;
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_gf2m_alu.sv
// Self-checking bench for gf2m_alu: directed cases plus random operands
// checked against a schoolbook GF(2^163) reference model.
module tb_gf2m_alu;

  localparam int unsigned  M    = 163;
  localparam int unsigned  K_W  = 8;
  localparam logic [M-1:0] POLY = 163'hC9;
`ifdef GF2M_SQR_CHAIN_EN
  localparam bit Chain = 1'b1;
`else
  localparam bit Chain = 1'b0;
`endif
  localparam int LatBound = 400;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [1:0]     op;
  logic [K_W-1:0] k;
  logic [M-1:0]   a;
  logic [M-1:0]   b;
  logic [M-1:0]   c;
  logic           busy;
  logic           done;
  logic           err;

  int n_checks = 0;
  int n_fail   = 0;

  gf2m_alu #(
    .M    (M),
    .POLY (POLY),
    .K_W  (K_W)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .op_i    (op),
    .k_i     (k),
    .a_i     (a),
    .b_i     (b),
    .c_o     (c),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Full carry-less product followed by long division by x^M + POLY.
  function automatic logic [M-1:0] ref_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [2*M-1:0] p;
    logic [2*M-1:0] modulus;
    p       = '0;
    modulus = {{(M - 1){1'b0}}, 1'b1, POLY};
    for (int i = 0; i < int'(M); i++) begin
      if (y[i]) p = p ^ ({{M{1'b0}}, x} << i);
    end
    for (int i = 2 * int'(M) - 2; i >= int'(M); i--) begin
      if (p[i]) p = p ^ (modulus << (i - int'(M)));
    end
    return p[M-1:0];
  endfunction

  function automatic int sqr_count(input logic [K_W-1:0] kk);
    if (!Chain) return 1;
    return (kk == '0) ? 1 : int'(kk);
  endfunction

  function automatic logic [M-1:0] ref_sqr(input logic [M-1:0] x, input logic [K_W-1:0] kk);
    logic [M-1:0] z;
    z = x;
    for (int i = 0; i < sqr_count(kk); i++) z = ref_mul(z, z);
    return z;
  endfunction

  function automatic logic [M-1:0] rnd();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[M-1:0];
  endfunction

  task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check result, err, latency and the done pulse.
  // poke_at: cycle after acceptance at which start is raised again (0 = none).
  // rst_at : cycle after acceptance at which reset is applied (0 = none).
  task automatic run_op(input string tag, input logic [1:0] t_op, input logic [K_W-1:0] t_k,
                        input logic [M-1:0] t_a, input logic [M-1:0] t_b,
                        input logic [M-1:0] exp_c, input logic exp_err, input int exp_lat,
                        input int poke_at, input int rst_at);
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    op    = t_op;
    k     = t_k;
    a     = t_a;
    b     = t_b;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands must have been captured; scramble the inputs.
    op    = 2'($urandom);
    k     = K_W'($urandom);
    a     = rnd();
    b     = rnd();
    check({tag, " busy_after_accept"}, M'(busy), M'(1'b1));
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LatBound) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        seen = 1'b1;
      end else begin
        start = (cyc == poke_at);
        if (cyc == rst_at) begin
          #2;
          rst_n = 1'b0;
          #1;
          check({tag, " rst_c"}, c, '0);
          check({tag, " rst_busy"}, M'(busy), '0);
          check({tag, " rst_done"}, M'(done), '0);
          check({tag, " rst_err"}, M'(err), '0);
          for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check({tag, " rst_no_done"}, M'(done), '0);
          end
          rst_n = 1'b1;
          @(posedge clk);
          #1;
          check({tag, " after_rst_no_done"}, M'(done), '0);
          check({tag, " after_rst_busy"}, M'(busy), '0);
          return;
        end
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, M'(seen), M'(1'b1));
    check({tag, " latency"}, M'(cyc), M'(exp_lat));
    check({tag, " c"}, c, exp_c);
    check({tag, " err"}, M'(err), M'(exp_err));
    check({tag, " busy_at_done"}, M'(busy), '0);
    @(posedge clk);
    #1;
    check({tag, " done_single"}, M'(done), '0);
    check({tag, " c_hold"}, c, exp_c);
  endtask

  initial begin
    logic [M-1:0]   ra;
    logic [M-1:0]   rb;
    logic [K_W-1:0] rk;
    logic [1:0]     rop;
    logic [M-1:0]   x162;
    logic [M-1:0]   x82;

    rst_n = 1'b0;
    start = 1'b0;
    op    = '0;
    k     = '0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset c", c, '0);
    check("reset busy", M'(busy), '0);
    check("reset done", M'(done), '0);
    check("reset err", M'(err), '0);
    rst_n = 1'b1;
    @(posedge clk);

    x162 = '0;
    x162[162] = 1'b1;
    x82 = '0;
    x82[82] = 1'b1;

    run_op("mult_1x2", 2'b00, '0, M'(1), M'(2), M'(2), 1'b0, M + 1, 0, 0);
    run_op("mult_x162", 2'b00, '0, x162, M'(2), M'(163'hC9), 1'b0, M + 1, 0, 0);
    run_op("sqr_x82", 2'b01, K_W'(1), x82, '0, M'(163'h192), 1'b0, 2, 0, 0);
    run_op("sqr_chain3", 2'b01, K_W'(3), M'(2), '0, Chain ? M'(163'h100) : M'(4), 1'b0,
           Chain ? 4 : 2, 0, 0);
    run_op("sqr_k0", 2'b01, '0, M'(2), '0, M'(4), 1'b0, 2, 0, 0);
    run_op("add", 2'b10, '0, M'(8'hF0), M'(8'h0F), M'(8'hFF), 1'b0, 2, 0, 0);
    run_op("rsvd", 2'b11, '0, M'(8'hF0), M'(8'h0F), '0, 1'b1, 2, 0, 0);
    run_op("mult_poke", 2'b00, '0, M'(1), M'(2), M'(2), 1'b0, M + 1, 50, 0);
    // No second completion from the ignored start.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("poke no_second_done", M'(done), '0);
    end
    run_op("mult_abort", 2'b00, '0, rnd(), rnd(), '0, 1'b0, M + 1, 0, 50);
    run_op("mult_after_rst", 2'b00, '0, M'(1), M'(2), M'(2), 1'b0, M + 1, 0, 0);

    for (int n = 0; n < 10; n++) begin
      ra  = rnd();
      rb  = rnd();
      rk  = K_W'($urandom_range(0, 12));
      rop = 2'($urandom_range(0, 3));
      case (rop)
        2'b00: run_op("rand_mult", rop, rk, ra, rb, ref_mul(ra, rb), 1'b0, M + 1, 0, 0);
        2'b01: run_op("rand_sqr", rop, rk, ra, rb, ref_sqr(ra, rk), 1'b0, sqr_count(rk) + 1,
                      0, 0);
        2'b10: run_op("rand_add", rop, rk, ra, rb, ra ^ rb, 1'b0, 2, 0, 0);
        default: run_op("rand_rsvd", rop, rk, ra, rb, '0, 1'b1, 2, 0, 0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
